// File: rtl/reg_block_transfer_seq_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package reg_block_transfer_seq_pkg;

  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 15;
  localparam int WORD_BYTES   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_WB,
    ST_BASE_WB,
    ST_FIN
  } state_e;

endpackage

// File: rtl/reg_block_transfer_seq_scan.sv
// Lowest-set-bit finder for the register list plus an any-set flag.
module reg_list_scan #(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 15
) (
  input  logic [NUM_REGS-1:0] list_i,
  output logic [ADDR_W-1:0]   idx_o,
  output logic                any_o
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    idx_o = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (list_i[i]) idx_o = ADDR_W'(i);
    end
  end

  assign any_o = |list_i;

endmodule

// File: rtl/reg_block_transfer_seq.sv
// LDM/STM sequencer: walks the register list, issues one memory request at a
// time and drives register-file writes for loads and the optional base writeback.
module reg_block_transfer_seq
  import reg_block_transfer_seq_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_load,
  input  logic [NUM_REGS-1:0] reg_list,
  input  logic [DATA_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   base_reg,
  input  logic                up,
  input  logic                pre,
  input  logic                wback,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rd_src,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                wb_en,
  output logic [ADDR_W-1:0]   wb_dest,
  output logic [DATA_W-1:0]   wb_value,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_write,
  output logic [DATA_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data
);

  localparam logic [DATA_W-1:0] WORD_STEP = DATA_W'(WORD_BYTES);

  state_e              state_q;
  logic [NUM_REGS-1:0] list_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   final_base_q;
  logic [ADDR_W-1:0]   base_reg_q;
  logic                is_load_q;
  logic                wback_q;
  logic                base_in_list_q;
  logic                busy_q;
  logic                done_q;
  logic                wb_en_q;
  logic [ADDR_W-1:0]   wb_dest_q;
  logic [DATA_W-1:0]   wb_value_q;
  logic                req_valid_q;
  logic                req_write_q;

  // In IDLE the scanner looks at the incoming list (empty-start check);
  // otherwise it tracks the latched list and yields the current register.
  logic [NUM_REGS-1:0] scan_list;
  logic [ADDR_W-1:0]   cur_idx;
  logic                scan_any;

  assign scan_list = (state_q == ST_IDLE) ? reg_list : list_q;

  reg_list_scan #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_scan (
    .list_i(scan_list),
    .idx_o (cur_idx),
    .any_o (scan_any)
  );

  logic [DATA_W-1:0]   n_regs;
  logic [DATA_W-1:0]   span;
  logic [DATA_W-1:0]   start_addr;
  logic [DATA_W-1:0]   final_base;
  logic                base_hit;

  always_comb begin
    n_regs   = '0;
    base_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      n_regs = n_regs + DATA_W'(reg_list[i]);
      if (reg_list[i] && base_reg == ADDR_W'(i)) base_hit = 1'b1;
    end
    span = n_regs * WORD_STEP;
    case ({up, pre})
      2'b10:   start_addr = base_addr;
      2'b11:   start_addr = base_addr + WORD_STEP;
      2'b00:   start_addr = base_addr - span + WORD_STEP;
      default: start_addr = base_addr - span;
    endcase
    final_base = up ? base_addr + span : base_addr - span;
  end

  // One register finished: drop its list bit and pick what follows.
  logic [NUM_REGS-1:0] rest_list;
  logic                advance;
  logic                do_base_wb;

  assign rest_list  = list_q & (list_q - NUM_REGS'(1));
  assign advance    = (state_q == ST_WB) ||
                      (state_q == ST_ISSUE && mem_req_ready && !is_load_q);
  assign do_base_wb = wback_q && !(is_load_q && base_in_list_q);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // right-hand side sees pre-edge values and later assignments cleanly override defaults.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      list_q         <= '0;
      addr_q         <= '0;
      final_base_q   <= '0;
      base_reg_q     <= '0;
      is_load_q      <= 1'b0;
      wback_q        <= 1'b0;
      base_in_list_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      wb_en_q        <= 1'b0;
      wb_dest_q      <= '0;
      wb_value_q     <= '0;
      req_valid_q    <= 1'b0;
      req_write_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wb_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            list_q         <= reg_list;
            addr_q         <= start_addr;
            final_base_q   <= final_base;
            base_reg_q     <= base_reg;
            is_load_q      <= is_load;
            wback_q        <= wback;
            base_in_list_q <= base_hit;
            busy_q         <= 1'b1;
            req_write_q    <= !is_load;
            if (scan_any) begin
              state_q     <= ST_ISSUE;
              req_valid_q <= 1'b1;
            end else begin
              state_q <= ST_FIN;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            if (is_load_q) state_q <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (mem_rsp_valid) begin
            wb_en_q    <= 1'b1;
            wb_dest_q  <= cur_idx;
            wb_value_q <= mem_rsp_data;
            state_q    <= ST_WB;
          end
        end
        ST_BASE_WB: state_q <= ST_FIN;
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (advance) begin
        list_q <= rest_list;
        addr_q <= addr_q + WORD_STEP;
        if (|rest_list) begin
          state_q     <= ST_ISSUE;
          req_valid_q <= 1'b1;
        end else if (do_base_wb) begin
          state_q    <= ST_BASE_WB;
          wb_en_q    <= 1'b1;
          wb_dest_q  <= base_reg_q;
          wb_value_q <= final_base_q;
        end else begin
          state_q <= ST_FIN;
        end
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rd_src        = (state_q == ST_IDLE) ? '0 : cur_idx;
  assign wb_en         = wb_en_q;
  assign wb_dest       = wb_dest_q;
  assign wb_value      = wb_value_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_write = req_write_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = (req_valid_q && req_write_q) ? rd_data : '0;

endmodule
